fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute datapath. It owns the fetch PC, issues word requests to a variable-latency instruction memory (one outstanding request at most), and buffers returned instructions with their PCs in a small FIFO. The core consumes {pc, instr} pairs over a valid/ready handshake. A redirect input from branch resolution flushes the queue and discards any in-flight fetch.

---
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Owns the fetch PC, keeps at most one
// request outstanding to a variable-latency instruction memory, and buffers
// returned {pc, instr} pairs in a small FIFO for the decode/execute stage.
// A redirect flushes the FIFO and discards whatever fetch is still in flight.
//
// state   | meaning
// ST_REQ  | may issue a request (when the FIFO has room)
// ST_WAIT | one request outstanding, its data will be kept
// ST_DROP | one request outstanding, its data will be thrown away
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          issue;
    logic          push;
    logic          pop;

    assign full      = (count_q == DEPTH_C);
    // Outputs are forced quiet while reset is held so nothing leaks out
    // before the registers have been cleared.
    assign imem_req  = !rst && (state_q == ST_REQ) && !full;
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;
    assign push      = (state_q == ST_WAIT) && imem_rvalid && !redirect;
    assign out_valid = !rst && (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];

    // Next FIFO pointers and occupancy; a redirect empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Fetch FSM together with the fetch PC and the PC of the outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
            case (state_q)
                // A request granted in the redirect cycle is still owed a response.
                ST_REQ:  state_q <= issue ? ST_DROP : ST_REQ;
                ST_WAIT: state_q <= imem_rvalid ? ST_REQ : ST_DROP;
                // Already draining; a response landing this very cycle ends the
                // drain, otherwise keep waiting for it.
                ST_DROP: state_q <= imem_rvalid ? ST_REQ : ST_DROP;
                default: state_q <= ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (issue) begin
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) state_q <= ST_REQ;
                end
                ST_DROP: begin
                    if (imem_rvalid) state_q <= ST_REQ;
                end
                default: state_q <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with a scoreboard of expected
// {pc, instr} pairs popped by an output monitor, plus point checks on the
// memory-side interface. A second instance covers a non-zero RESET_PC.
module tb_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (RESET_PC = 0)
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    // wrap instance (RESET_PC = FFFF_FFF8)
    logic        w_rst;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_instr;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wexp_q[$];
    logic [63:0] m_e;
    logic [63:0] w_e;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_pc(w_out_pc), .out_instr(w_out_instr)
    );

    // Memory model for the main instance: returns addr ^ A5A5_0000, lat cycles after issue.
    int          lat = 1;
    int          pend_cnt = 0;
    int          issue_cnt = 0;
    logic [31:0] last_addr = 32'h0;
    always @(posedge clk) begin
        if (rst) begin
            pend_cnt <= 0;
        end else if (imem_req && imem_gnt) begin
            last_addr <= imem_addr;
            pend_cnt  <= lat;
            issue_cnt <= issue_cnt + 1;
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end
    assign imem_rvalid = (pend_cnt == 1);
    assign imem_rdata  = last_addr ^ 32'hA5A5_0000;

    // Memory model for the wrap instance: grant always, one-cycle latency.
    int          w_pend = 0;
    logic [31:0] w_last = 32'h0;
    always @(posedge clk) begin
        if (w_rst) begin
            w_pend <= 0;
        end else if (w_req && w_gnt) begin
            w_last <= w_addr;
            w_pend <= 1;
        end else if (w_pend > 0) begin
            w_pend <= w_pend - 1;
        end
    end
    assign w_gnt         = 1'b1;
    assign w_rvalid      = (w_pend == 1);
    assign w_rdata       = w_last ^ 32'hA5A5_0000;
    assign w_redirect    = 1'b0;
    assign w_redirect_pc = 32'h0;

    // Output monitors: every accepted head must match the next scoreboard entry.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
            end else begin
                m_e = exp_q.pop_front();
                if ({out_pc, out_instr} !== m_e) begin
                    errors++;
                    $display("FAIL out_pair: got pc=%h instr=%h, required pc=%h instr=%h",
                             out_pc, out_instr, m_e[63:32], m_e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (w_out_valid && w_out_ready) begin
            checks++;
            if (wexp_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_unexpected: got pc=%h instr=%h, required no output", w_out_pc, w_out_instr);
            end else begin
                w_e = wexp_q.pop_front();
                if ({w_out_pc, w_out_instr} !== w_e) begin
                    errors++;
                    $display("FAIL wrap_pair: got pc=%h instr=%h, required pc=%h instr=%h",
                             w_out_pc, w_out_instr, w_e[63:32], w_e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drain(input bit w, input int budget, input string name);
        int n = 0;
        while (((w ? wexp_q.size() : exp_q.size()) != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if ((w ? wexp_q.size() : exp_q.size()) != 0) begin
            errors++;
            $display("FAIL %s: %0d outputs outstanding after %0d cycles, required 0",
                     name, (w ? wexp_q.size() : exp_q.size()), budget);
            if (w) wexp_q.delete(); else exp_q.delete();
        end
    endtask

    // Hold the main instance in reset, check its quiet outputs, end just after
    // a reset edge so the caller can release rst.
    task automatic reset_main();
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b1; imem_gnt = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        w_rst = 1'b1; w_out_ready = 1'b0;

        // 1: streaming fetch, gnt=1, latency 1
        reset_main();
        lat = 1; imem_gnt = 1'b1; out_ready = 1'b1;
        exp_q.push_back({32'h0000_0000, 32'hA5A5_0000});
        exp_q.push_back({32'h0000_0004, 32'hA5A5_0004});
        exp_q.push_back({32'h0000_0008, 32'hA5A5_0008});
        exp_q.push_back({32'h0000_000C, 32'hA5A5_000C});
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0000_0000);
        @(negedge clk);
        chk("latency_valid", {31'h0, out_valid}, 32'h0);
        drain(1'b0, 40, "drain_stream");
        #1; imem_gnt = 1'b0; out_ready = 1'b0;

        // 2: fill to DEPTH with out_ready low, then a single pop
        reset_main();
        lat = 1; imem_gnt = 1'b1; out_ready = 1'b0;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("full_req", {31'h0, imem_req}, 32'h0);
        chk("full_valid", {31'h0, out_valid}, 32'h1);
        chk("full_head", out_pc, 32'h0000_0000);
        exp_q.push_back({32'h0000_0000, 32'hA5A5_0000});
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        chk("refill_req", {31'h0, imem_req}, 32'h1);
        chk("refill_addr", imem_addr, 32'h0000_0010);
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back({32'h0000_0004, 32'hA5A5_0004});
        exp_q.push_back({32'h0000_0008, 32'hA5A5_0008});
        exp_q.push_back({32'h0000_000C, 32'hA5A5_000C});
        exp_q.push_back({32'h0000_0010, 32'hA5A5_0010});
        out_ready = 1'b1;
        drain(1'b0, 40, "drain_full");
        #1; imem_gnt = 1'b0; out_ready = 1'b0;

        // 3: redirect while waiting, stale response arrives later
        reset_main();
        lat = 3; imem_gnt = 1'b1; out_ready = 1'b1;
        exp_q.push_back({32'h0000_1000, 32'hA5A5_1000});
        rst = 1'b0;
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_1003;
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        chk("wait_rd_empty", {31'h0, out_valid}, 32'h0);
        chk("wait_rd_noreq", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        chk("drop_noreq", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        chk("wait_rd_req", {31'h0, imem_req}, 32'h1);
        chk("wait_rd_addr", imem_addr, 32'h0000_1000);
        drain(1'b0, 40, "drain_wait_rd");
        #1; imem_gnt = 1'b0; out_ready = 1'b0;

        // 4: redirect coinciding with the grant of address 0x8
        reset_main();
        lat = 1; imem_gnt = 1'b1; out_ready = 1'b1;
        exp_q.push_back({32'h0000_0000, 32'hA5A5_0000});
        exp_q.push_back({32'h0000_0004, 32'hA5A5_0004});
        exp_q.push_back({32'h0000_0200, 32'hA5A5_0200});
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("gnt_rd_addr", imem_addr, 32'h0000_0008);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        chk("gnt_rd_drop", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        chk("gnt_rd_req", {31'h0, imem_req}, 32'h1);
        chk("gnt_rd_addr2", imem_addr, 32'h0000_0200);
        drain(1'b0, 40, "drain_gnt_rd");
        #1; imem_gnt = 1'b0; out_ready = 1'b0;

        // 5: grant stall with a redirect in the middle
        reset_main();
        lat = 1; imem_gnt = 1'b0; out_ready = 1'b1;
        exp_q.push_back({32'h0000_0300, 32'hA5A5_0300});
        rst = 1'b0;
        @(negedge clk);
        chk("stall_addr0", imem_addr, 32'h0000_0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_stable", imem_addr, 32'h0000_0000);
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_0300;
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        chk("stall_req", {31'h0, imem_req}, 32'h1);
        chk("stall_newaddr", imem_addr, 32'h0000_0300);
        base = issue_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1; imem_gnt = 1'b1;
        @(posedge clk); #1; imem_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_issues", 32'(issue_cnt - base), 32'h1);
        chk("stall_issue_addr", last_addr, 32'h0000_0300);
        drain(1'b0, 20, "drain_stall");
        #1; out_ready = 1'b0;
        rst = 1'b1;

        // 6: RESET_PC near the top of the address space, reset mid-WAIT
        w_out_ready = 1'b1;
        wexp_q.push_back({32'hFFFF_FFF8, 32'h5A5A_FFF8});
        wexp_q.push_back({32'hFFFF_FFFC, 32'h5A5A_FFFC});
        wexp_q.push_back({32'h0000_0000, 32'hA5A5_0000});
        @(posedge clk); #1; w_rst = 1'b0;
        @(negedge clk);
        chk("wrap_req", {31'h0, w_req}, 32'h1);
        chk("wrap_addr", w_addr, 32'hFFFF_FFF8);
        drain(1'b1, 40, "drain_wrap");
        #1; w_out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wrap_pre_rst", {31'h0, w_out_valid}, 32'h1);
        w_rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_rst_valid", {31'h0, w_out_valid}, 32'h0);
        chk("wrap_rst_req", {31'h0, w_req}, 32'h0);
        @(posedge clk); #1; w_rst = 1'b0;
        wexp_q.push_back({32'hFFFF_FFF8, 32'h5A5A_FFF8});
        w_out_ready = 1'b1;
        @(negedge clk);
        chk("wrap_restart_req", {31'h0, w_req}, 32'h1);
        chk("wrap_restart_addr", w_addr, 32'hFFFF_FFF8);
        chk("wrap_restart_empty", {31'h0, w_out_valid}, 32'h0);
        drain(1'b1, 20, "drain_wrap_restart");
        #1; w_rst = 1'b1;

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
